uart_rx_sampler: RTL and testbench

Board-side UART receiver for the host-to-board serial link on the GPIO header. It deserializes 8N1 frames arriving on `rxd` using 16x oversampling with a 3-sample majority vote. Each received byte is presented to fabric logic, such as a boot loader or debug command decoder, through a valid/ready holding register. It is the receiving end of the link whose transmit side is the host/soft-core UART, and it reports framing and overrun errors.

---
 rtl/uart_rx_sampler_if.sv | 31 +++
 rtl/uart_rx_sampler.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// The receiver is the master (it produces bytes); fabric logic is the slave.
interface uart_rx_sampler_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       framing_err;
  logic       overrun;
  logic       overrun_clr;
  logic       busy;

  modport master (
    output data_out,
    output data_valid,
    output framing_err,
    output overrun,
    output busy,
    input  data_ready,
    input  overrun_clr
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  framing_err,
    input  overrun,
    input  busy,
    output data_ready,
    output overrun_clr
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit,
// single-entry valid/ready holding register with framing and overrun reporting.
module uart_rx_sampler #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  uart_rx_sampler_if.master rx_if
);

  localparam int DIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx_sampler: CLK_HZ too low for BAUD, oversample divider is zero");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             rxs_q, rxs_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       sample_q, sample_d;
  logic [2:0]       bit_q, bit_d;
  logic             s7_q, s7_d;
  logic             s8_q, s8_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             framing_err_q, framing_err_d;
  logic             overrun_q, overrun_d;

  logic tick;
  logic vote;
  logic accept;
  logic deliver;
  logic frame_bad;
  logic overrun_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      div_q         <= '0;
      sample_q      <= '0;
      bit_q         <= '0;
      s7_q          <= 1'b1;
      s8_q          <= 1'b1;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      rxs_q         <= rxs_d;
      div_q         <= div_d;
      sample_q      <= sample_d;
      bit_q         <= bit_d;
      s7_q          <= s7_d;
      s8_q          <= s8_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sync1_d       = rxd;
    rxs_d         = sync1_q;
    div_d         = div_q;
    sample_d      = sample_q;
    bit_d         = bit_q;
    s7_d          = s7_q;
    s8_d          = s8_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = data_valid_q;
    framing_err_d = 1'b0;
    overrun_d     = overrun_q;
    deliver       = 1'b0;
    frame_bad     = 1'b0;
    overrun_set   = 1'b0;

    tick   = (div_q == DIV_LAST);
    vote   = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    accept = data_valid_q & rx_if.data_ready;

    // Samples 7 and 8 are latched; sample 9 is voted live together with them.
    if (tick) begin
      div_d    = '0;
      sample_d = sample_q + 4'd1;
      if (sample_q == 4'd7) s7_d = rxs_q;
      if (sample_q == 4'd8) s8_d = rxs_q;
    end else begin
      div_d = div_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        div_d    = '0;
        sample_d = '0;
        bit_d    = '0;
        if (!rxs_q) state_d = ST_START;
      end

      ST_START: begin
        if (tick && sample_q == 4'd9 && vote) begin
          state_d = ST_IDLE;
        end else if (tick && sample_q == 4'd15) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end

      ST_DATA: begin
        if (tick && sample_q == 4'd9) shift_d = {vote, shift_q[7:1]};
        if (tick && sample_q == 4'd15) begin
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end

      // Leaving at sample 9 of the stop bit lets a back-to-back start be caught early.
      ST_STOP: begin
        if (tick && sample_q == 4'd9) begin
          if (vote) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end

      ST_BREAK: begin
        div_d    = '0;
        sample_d = '0;
        if (rxs_q) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (accept) data_valid_d = 1'b0;

    // A same-cycle accept frees the holding register for the new byte.
    if (deliver) begin
      if (!data_valid_q || accept) begin
        data_out_d   = shift_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end

    framing_err_d = frame_bad;

    if (overrun_set)            overrun_d = 1'b1;
    else if (rx_if.overrun_clr) overrun_d = 1'b0;
  end

  assign rx_if.data_out    = data_out_q;
  assign rx_if.data_valid  = data_valid_q;
  assign rx_if.framing_err = framing_err_q;
  assign rx_if.overrun     = overrun_q;
  assign rx_if.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: frames are driven bit by bit, the expected
// outcome of each frame is queued, and a negedge monitor checks what the DUT presents.
module tb_uart_rx_sampler;

  localparam int CLK_HZ    = 7_372_800;
  localparam int BAUD      = 115200;
  localparam int DIV       = 4;
  localparam int BIT_CYC   = 16 * DIV;
  localparam int FRAME_CYC = 10 * BIT_CYC;
  // rxd edge to T0 is two synchronizer cycles; the stop vote is tick 154; output is one cycle later.
  localparam int VALID_LAT = 2 + 154 * DIV + 1;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rxd   = 1'b1;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   model_full  = 1'b0;
  bit   overrun_exp = 1'b0;
  int   frame_start    = 0;
  int   line_high_cyc  = 0;
  int   busy_rise_cyc  = -1;
  int   busy_fall_cyc  = -1;
  int   valid_fall_cyc = -1;
  logic prev_valid  = 1'b0;
  logic prev_accept = 1'b0;
  logic prev_busy   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_data_out"},    rx_if.data_out,    32'h00);
    checkOutput({tag, "_data_valid"},  rx_if.data_valid,  32'h0);
    checkOutput({tag, "_framing_err"}, rx_if.framing_err, 32'h0);
    checkOutput({tag, "_overrun"},     rx_if.overrun,     32'h0);
    checkOutput({tag, "_busy"},        rx_if.busy,        32'h0);
  endtask

  // Monitor: pops the scoreboard whenever a byte is loaded or a framing error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_if.framing_err) begin
        checkOutput("ferr_was_expected", sb.size() > 0, 32'h1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checkOutput("ferr_kind", mon_e.is_ferr, 32'h1);
          checkOutput("ferr_cycle", cyc, mon_e.cyc);
        end
      end
      if (rx_if.data_valid && (!prev_valid || prev_accept)) begin
        checkOutput("byte_was_expected", sb.size() > 0, 32'h1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checkOutput("byte_kind", mon_e.is_ferr, 32'h0);
          checkOutput("byte_data", rx_if.data_out, mon_e.data);
          checkOutput("byte_cycle", cyc, mon_e.cyc);
        end
      end
    end
    if (rx_if.busy && !prev_busy)        busy_rise_cyc  = cyc;
    if (!rx_if.busy && prev_busy)        busy_fall_cyc  = cyc;
    if (!rx_if.data_valid && prev_valid) valid_fall_cyc = cyc;
    prev_valid  <= rx_if.data_valid;
    prev_accept <= rx_if.data_valid & rx_if.data_ready;
    prev_busy   <= rx_if.busy;
  end

  // Drives one 8N1 frame and queues its expected outcome. Optional: flip one oversample,
  // pulse data_ready at a frame offset, hit reset at a frame offset, hold the line low after.
  task automatic applyStimulus(input logic [7:0] data, input bit stop_bit,
                               input int flip_bit, input int flip_sample,
                               input int ready_pulse_off, input int reset_off,
                               input int tail_low);
    int c;
    int k;
    int n;
    bit lvl;
    bit ready_at_done;
    c = cyc;
    frame_start = c;
    if (reset_off < 0) begin
      if (!stop_bit) begin
        sb.push_back('{1'b1, 8'h00, c + VALID_LAT});
      end else begin
        ready_at_done = (ready_pulse_off == VALID_LAT - 1) ? 1'b1 : rx_if.data_ready;
        if (!model_full || ready_at_done) begin
          sb.push_back('{1'b0, data, c + VALID_LAT});
          model_full = 1'b1;
        end else begin
          overrun_exp = 1'b1;
        end
      end
    end else begin
      model_full  = 1'b0;
      overrun_exp = 1'b0;
    end
    for (int i = 0; i < FRAME_CYC; i++) begin
      k = i / BIT_CYC;
      if (k == 0)      lvl = 1'b0;
      else if (k <= 8) lvl = data[k-1];
      else             lvl = stop_bit;
      if (flip_bit == k) begin
        n = 16 * k + flip_sample + 1;
        if (i >= DIV * n - DIV / 2 && i < DIV * n + DIV / 2) lvl = ~lvl;
      end
      rxd = lvl;
      if (i == ready_pulse_off) rx_if.data_ready = 1'b1;
      else if (ready_pulse_off >= 0 && i == ready_pulse_off + 1) rx_if.data_ready = 1'b0;
      if (i == reset_off) begin
        reset = 1'b1;
      end else if (reset_off >= 0 && i == reset_off + 1) begin
        reset = 1'b0;
        checkResetState("midframe_reset");
      end
      @(posedge clk);
      #1;
    end
    if (tail_low > 0) begin
      rxd = 1'b0;
      waitCycles(tail_low);
    end
    rxd = 1'b1;
    line_high_cyc = cyc;
    if (rx_if.data_ready) model_full = 1'b0;
  endtask

  initial begin
    int gfall;
    logic [7:0] rnd_data;
    bit rnd_stop;
    int rnd_fb;
    int rnd_fs;

    rx_if.data_ready  = 1'b1;
    rx_if.overrun_clr = 1'b0;
    reset = 1'b1;
    rxd   = 1'b1;
    waitCycles(3);
    checkResetState("reset");
    reset = 1'b0;
    waitCycles(5);

    $display("[TB] nominal 0xA5");
    applyStimulus(8'hA5, 1'b1, -1, 0, -1, -1, 0);
    checkOutput("a5_busy_rise", busy_rise_cyc, frame_start + 3);
    checkOutput("a5_busy_fall", busy_fall_cyc, frame_start + VALID_LAT);
    checkOutput("a5_valid_fall", valid_fall_cyc, frame_start + VALID_LAT + 1);
    checkOutput("a5_sb_empty", sb.size(), 0);
    waitCycles(20);

    $display("[TB] start glitch");
    gfall = cyc;
    rxd = 1'b0;
    waitCycles(3);
    rxd = 1'b1;
    waitCycles(60);
    checkOutput("glitch_busy_rise", busy_rise_cyc, gfall + 3);
    checkOutput("glitch_busy_fall", busy_fall_cyc, gfall + 2 + 41);
    checkOutput("glitch_no_valid", rx_if.data_valid, 0);

    $display("[TB] single-sample flip in 0x0F");
    applyStimulus(8'h0F, 1'b1, 4, 8, -1, -1, 0);
    checkOutput("flip_sb_empty", sb.size(), 0);
    waitCycles(20);

    $display("[TB] framing error then recovery");
    applyStimulus(8'h3C, 1'b0, -1, 0, -1, -1, 40 * DIV);
    waitCycles(10);
    checkOutput("ferr_busy_fall", busy_fall_cyc, line_high_cyc + 3);
    checkOutput("ferr_sb_empty", sb.size(), 0);
    waitCycles(10);
    applyStimulus(8'h81, 1'b1, -1, 0, -1, -1, 0);
    checkOutput("recover_sb_empty", sb.size(), 0);
    waitCycles(20);

    $display("[TB] overrun");
    rx_if.data_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, -1, 0, -1, -1, 0);
    waitCycles(10);
    applyStimulus(8'h22, 1'b1, -1, 0, -1, -1, 0);
    waitCycles(10);
    checkOutput("ovr_data_out", rx_if.data_out, 8'h11);
    checkOutput("ovr_data_valid", rx_if.data_valid, 1);
    checkOutput("ovr_flag_set", rx_if.overrun, overrun_exp);
    rx_if.overrun_clr = 1'b1;
    waitCycles(1);
    rx_if.overrun_clr = 1'b0;
    overrun_exp = 1'b0;
    checkOutput("ovr_flag_clr", rx_if.overrun, overrun_exp);
    checkOutput("ovr_data_kept", rx_if.data_out, 8'h11);
    waitCycles(10);

    $display("[TB] accept and reload in the same cycle");
    applyStimulus(8'h22, 1'b1, -1, 0, VALID_LAT - 1, -1, 0);
    waitCycles(5);
    checkOutput("reload_data_out", rx_if.data_out, 8'h22);
    checkOutput("reload_valid", rx_if.data_valid, 1);
    checkOutput("reload_overrun", rx_if.overrun, overrun_exp);
    checkOutput("reload_sb_empty", sb.size(), 0);

    $display("[TB] reset mid-frame");
    rx_if.data_ready = 1'b1;
    waitCycles(3);
    model_full = 1'b0;
    applyStimulus(8'hFF, 1'b1, -1, 0, -1, 5 * BIT_CYC + 20, 0);
    waitCycles(20);
    checkOutput("rst_no_valid", rx_if.data_valid, 0);
    applyStimulus(8'h5A, 1'b1, -1, 0, -1, -1, 0);
    waitCycles(5);
    checkOutput("rst_next_sb_empty", sb.size(), 0);
    checkOutput("rst_next_overrun", rx_if.overrun, 0);

    $display("[TB] randomized frames");
    for (int r = 0; r < 16; r++) begin
      rnd_data = 8'($urandom);
      rnd_stop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1) begin
        rnd_fb = $urandom_range(1, 8);
        rnd_fs = $urandom_range(7, 9);
      end else begin
        rnd_fb = -1;
        rnd_fs = 0;
      end
      applyStimulus(rnd_data, rnd_stop, rnd_fb, rnd_fs, -1, -1, 0);
      waitCycles($urandom_range(4, 80));
      checkOutput("rand_sb_empty", sb.size(), 0);
    end

    waitCycles(50);
    checkOutput("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
